// File: rtl/xalu_ise_pkg.sv
// Shared types and constants for the xalu_ise issue path: op record, response record,
// owner tag width and the custom-opcode map selected by fn[1:0].
package xalu_ise_pkg;

    localparam int unsigned ISE_XLEN = 64;
    localparam int unsigned FN_W     = 5;
    localparam int unsigned IMM_W    = 7;
    localparam int unsigned OWN_W    = 1;
    localparam int unsigned PERF_W   = 32;

    localparam logic [6:0] CUSTOM_0 = 7'b0001011;
    localparam logic [6:0] CUSTOM_1 = 7'b0101011;
    localparam logic [6:0] CUSTOM_2 = 7'b1011011;
    localparam logic [6:0] CUSTOM_3 = 7'b1111011;

    typedef struct packed {
        logic [FN_W-1:0]     fn;
        logic [IMM_W-1:0]    imm;
        logic [ISE_XLEN-1:0] in1;
        logic [ISE_XLEN-1:0] in2;
    } op_t;

    typedef struct packed {
        logic [ISE_XLEN-1:0] data;
        logic                err;
    } rsp_t;

    function automatic logic [6:0] custom_opcode(input logic [1:0] sel);
        logic [6:0] opc;
        unique case (sel)
            2'd0:    opc = CUSTOM_0;
            2'd1:    opc = CUSTOM_1;
            2'd2:    opc = CUSTOM_2;
            default: opc = CUSTOM_3;
        endcase
        return opc;
    endfunction

    // Saturating increment for the optional performance counters.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/xalu_rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer moves only when a grant is issued.
module xalu_rr_arb2 #(
    parameter int unsigned RR_INIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_c_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_c_o = 2'b00;
        if (en_i) begin
            unique case (req_i)
                2'b01:   gnt_c_o = 2'b01;
                2'b10:   gnt_c_o = 2'b10;
                2'b11:   gnt_c_o = last_q ? 2'b01 : 2'b10;
                default: gnt_c_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (|gnt_c_o) begin
            last_d = gnt_c_o[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'(RR_INIT);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/xalu_ise_arb.sv
// Two-requester arbiter and issue/response sequencer for the shared xalu_ise datapath.
// Optional performance counters are built when XALU_ARB_PERF_EN is defined.
module xalu_ise_arb
    import xalu_ise_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned RR_INIT = 1
) (
    input  logic             ise_clk,
    input  logic             ise_rst,
    input  logic             req0_val,
    output logic             req0_rdy,
    input  logic [FN_W-1:0]  req0_fn,
    input  logic [IMM_W-1:0] req0_imm,
    input  logic [XLEN-1:0]  req0_in1,
    input  logic [XLEN-1:0]  req0_in2,
    input  logic             req1_val,
    output logic             req1_rdy,
    input  logic [FN_W-1:0]  req1_fn,
    input  logic [IMM_W-1:0] req1_imm,
    input  logic [XLEN-1:0]  req1_in1,
    input  logic [XLEN-1:0]  req1_in2,
    output logic             rsp0_val,
    input  logic             rsp0_rdy,
    output logic [XLEN-1:0]  rsp0_data,
    output logic             rsp0_err,
    output logic             rsp1_val,
    input  logic             rsp1_rdy,
    output logic [XLEN-1:0]  rsp1_data,
    output logic             rsp1_err,
    output logic             ise_val,
    output logic [FN_W-1:0]  ise_fn,
    output logic [IMM_W-1:0] ise_imm,
    output logic [XLEN-1:0]  ise_in1,
    output logic [XLEN-1:0]  ise_in2,
    input  logic             ise_oval,
    input  logic [XLEN-1:0]  ise_out
`ifdef XALU_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_op0,
    output logic [PERF_W-1:0] perf_op1,
    output logic [PERF_W-1:0] perf_conf
`endif
);

    logic             a_vld_q, a_vld_d;
    logic [OWN_W-1:0] a_own_q, a_own_d;
    op_t              a_op_q,  a_op_d;
    logic             b_vld_q, b_vld_d;
    logic [OWN_W-1:0] b_own_q, b_own_d;
    rsp_t             b_rsp_q, b_rsp_d;

    logic       b_drain, b_load_ok, a_adv, a_load_ok;
    logic [1:0] gnt;

    // Pipeline flow: B frees when its owner takes it, A moves into a free B.
    assign b_drain   = b_vld_q & (b_own_q[0] ? rsp1_rdy : rsp0_rdy);
    assign b_load_ok = ~b_vld_q | b_drain;
    assign a_adv     = a_vld_q & b_load_ok;
    assign a_load_ok = ~a_vld_q | a_adv;

    // Grants are suppressed during reset so no request is acknowledged and then lost.
    xalu_rr_arb2 #(
        .RR_INIT (RR_INIT)
    ) u_arb (
        .clk     (ise_clk),
        .rst     (ise_rst),
        .en_i    (a_load_ok & ~ise_rst),
        .req_i   ({req1_val, req0_val}),
        .gnt_c_o (gnt)
    );

    always_comb begin
        a_vld_d = a_vld_q;
        a_own_d = a_own_q;
        a_op_d  = a_op_q;
        b_vld_d = b_vld_q;
        b_own_d = b_own_q;
        b_rsp_d = b_rsp_q;

        if (a_adv) begin
            b_vld_d      = 1'b1;
            b_own_d      = a_own_q;
            b_rsp_d.data = ise_oval ? ise_out : '0;
            b_rsp_d.err  = ~ise_oval;
        end else if (b_drain) begin
            b_vld_d = 1'b0;
        end

        if (gnt[1]) begin
            a_vld_d    = 1'b1;
            a_own_d    = OWN_W'(1);
            a_op_d.fn  = req1_fn;
            a_op_d.imm = req1_imm;
            a_op_d.in1 = req1_in1;
            a_op_d.in2 = req1_in2;
        end else if (gnt[0]) begin
            a_vld_d    = 1'b1;
            a_own_d    = OWN_W'(0);
            a_op_d.fn  = req0_fn;
            a_op_d.imm = req0_imm;
            a_op_d.in1 = req0_in1;
            a_op_d.in2 = req0_in2;
        end else if (a_adv) begin
            a_vld_d = 1'b0;
        end
    end

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            a_vld_q <= 1'b0;
            a_own_q <= '0;
            a_op_q  <= '0;
            b_vld_q <= 1'b0;
            b_own_q <= '0;
            b_rsp_q <= '0;
        end else begin
            a_vld_q <= a_vld_d;
            a_own_q <= a_own_d;
            a_op_q  <= a_op_d;
            b_vld_q <= b_vld_d;
            b_own_q <= b_own_d;
            b_rsp_q <= b_rsp_d;
        end
    end

    assign req0_rdy = gnt[0];
    assign req1_rdy = gnt[1];

    assign ise_val = a_adv;
    assign ise_fn  = a_op_q.fn;
    assign ise_imm = a_op_q.imm;
    assign ise_in1 = a_op_q.in1;
    assign ise_in2 = a_op_q.in2;

    // Response fields are visible only on the owning port.
    assign rsp0_val  = b_vld_q & (b_own_q == OWN_W'(0));
    assign rsp1_val  = b_vld_q & (b_own_q == OWN_W'(1));
    assign rsp0_data = rsp0_val ? b_rsp_q.data : '0;
    assign rsp1_data = rsp1_val ? b_rsp_q.data : '0;
    assign rsp0_err  = rsp0_val & b_rsp_q.err;
    assign rsp1_err  = rsp1_val & b_rsp_q.err;

`ifdef XALU_ARB_PERF_EN
    logic [PERF_W-1:0] perf_op0_q, perf_op0_d;
    logic [PERF_W-1:0] perf_op1_q, perf_op1_d;
    logic [PERF_W-1:0] perf_conf_q, perf_conf_d;

    always_comb begin
        perf_op0_d  = perf_op0_q;
        perf_op1_d  = perf_op1_q;
        perf_conf_d = perf_conf_q;
        if (rsp0_val & b_drain) begin
            perf_op0_d = sat_inc(perf_op0_q);
        end
        if (rsp1_val & b_drain) begin
            perf_op1_d = sat_inc(perf_op1_q);
        end
        if (req0_val & req1_val & a_load_ok) begin
            perf_conf_d = sat_inc(perf_conf_q);
        end
    end

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            perf_op0_q  <= '0;
            perf_op1_q  <= '0;
            perf_conf_q <= '0;
        end else begin
            perf_op0_q  <= perf_op0_d;
            perf_op1_q  <= perf_op1_d;
            perf_conf_q <= perf_conf_d;
        end
    end

    assign perf_op0  = perf_op0_q;
    assign perf_op1  = perf_op1_q;
    assign perf_conf = perf_conf_q;
`endif

endmodule
